// File: rtl/prefix_sequencer_pkg.sv
// Shared constants and types for the instruction prefix sequencer.
//   - segment codes, which are also used by the segment override unit
//   - 8086 prefix byte values
//   - REP qualifier encoding
//   - FSM state type and the classifier result struct
package prefix_sequencer_pkg;

  localparam logic [1:0] SEG_ES = 2'd0;
  localparam logic [1:0] SEG_CS = 2'd1;
  localparam logic [1:0] SEG_SS = 2'd2;
  localparam logic [1:0] SEG_DS = 2'd3;

  localparam logic [7:0] PFX_ES    = 8'h26;
  localparam logic [7:0] PFX_CS    = 8'h2E;
  localparam logic [7:0] PFX_SS    = 8'h36;
  localparam logic [7:0] PFX_DS    = 8'h3E;
  localparam logic [7:0] PFX_LOCK  = 8'hF0;
  localparam logic [7:0] PFX_REPNE = 8'hF2;
  localparam logic [7:0] PFX_REP   = 8'hF3;

  localparam logic [1:0] REP_NONE = 2'b00;
  localparam logic [1:0] REP_NE   = 2'b10;
  localparam logic [1:0] REP_E    = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } prefix_state_t;

  typedef struct packed {
    logic is_seg;
    logic is_lock;
    logic is_rep;
    logic rep_z;
  } prefix_class_t;

  // Segment code carried by a segment override prefix byte.
  function automatic logic [1:0] seg_code(input logic [7:0] b);
    case (b)
      PFX_ES:  seg_code = SEG_ES;
      PFX_CS:  seg_code = SEG_CS;
      PFX_SS:  seg_code = SEG_SS;
      default: seg_code = SEG_DS;
    endcase
  endfunction

endpackage

// File: rtl/prefix_sequencer_if.sv
// Bundle of the sequencer's control, prefetch-FIFO, override-unit and decoder signals.
//   master: the sequencer
//   slave : its surroundings (FIFO, decoder, override unit, control)
interface prefix_sequencer_if #(
  parameter int unsigned COUNT_W = 4
);
  logic               start;
  logic               flush;
  logic               fifo_empty;
  logic [7:0]         fifo_rd_data;
  logic               fifo_rd_en;
  logic               seg_update;
  logic               segment_override;
  logic [1:0]         override_in;
  logic [1:0]         rep;
  logic               lock;
  logic [COUNT_W-1:0] prefix_count;
  logic [7:0]         opcode;
  logic               opcode_valid;
  logic               opcode_ack;

  modport master (
    input  start, flush, fifo_empty, fifo_rd_data, opcode_ack,
    output fifo_rd_en, seg_update, segment_override, override_in,
           rep, lock, prefix_count, opcode, opcode_valid
  );

  modport slave (
    output start, flush, fifo_empty, fifo_rd_data, opcode_ack,
    input  fifo_rd_en, seg_update, segment_override, override_in,
           rep, lock, prefix_count, opcode, opcode_valid
  );
endinterface

// File: rtl/prefix_classify.sv
// Combinational classification of one instruction byte as an 8086 prefix.
//   data : candidate byte
//   cls  : {is_seg, is_lock, is_rep, rep_z}; rep_z is byte[0] (REP vs REPNE)
module prefix_classify
  import prefix_sequencer_pkg::*;
(
  input  logic [7:0]    data,
  output prefix_class_t cls
);

  always_comb begin
    cls         = '0;
    cls.is_seg  = (data == PFX_ES) || (data == PFX_CS) ||
                  (data == PFX_SS) || (data == PFX_DS);
    cls.is_lock = (data == PFX_LOCK);
    cls.is_rep  = (data == PFX_REPNE) || (data == PFX_REP);
    cls.rep_z   = data[0];
  end

endmodule

// File: rtl/prefix_sequencer.sv
// Prefix/opcode scanner between the prefetch FIFO, the decoder and the segment override unit.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (master) : start/flush control, show-ahead FIFO pop, seg_update pulse
//                  to the override unit, rep/lock/prefix_count qualifiers,
//                  opcode valid/ack to the decoder
module prefix_sequencer
  import prefix_sequencer_pkg::*;
#(
  parameter int unsigned COUNT_W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  prefix_sequencer_if.master bus
);

  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  prefix_state_t      state;
  logic               seg_update_q;
  logic               segment_override_q;
  logic [1:0]         override_in_q;
  logic [1:0]         rep_q;
  logic               lock_q;
  logic [COUNT_W-1:0] prefix_count_q;
  logic [7:0]         opcode_q;
  logic               opcode_valid_q;

  prefix_class_t      cls;
  logic               pop;
  logic [COUNT_W-1:0] count_inc;

  prefix_classify u_classify (
    .data (bus.fifo_rd_data),
    .cls  (cls)
  );

  // Pop directly from state so a reset drops the read enable asynchronously.
  assign pop       = (state == SCAN) && !bus.fifo_empty && !bus.flush;
  assign count_inc = (prefix_count_q == COUNT_MAX) ? prefix_count_q
                                                   : prefix_count_q + COUNT_W'(1);

  // FSM and qualifier registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state              <= IDLE;
      seg_update_q       <= 1'b0;
      segment_override_q <= 1'b0;
      override_in_q      <= SEG_ES;
      rep_q              <= REP_NONE;
      lock_q             <= 1'b0;
      prefix_count_q     <= '0;
      opcode_q           <= 8'h00;
      opcode_valid_q     <= 1'b0;
    end else begin
      seg_update_q       <= 1'b0;
      segment_override_q <= 1'b0;
      if (bus.flush) begin
        state          <= IDLE;
        opcode_valid_q <= 1'b0;
        rep_q          <= REP_NONE;
        lock_q         <= 1'b0;
        prefix_count_q <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              state          <= SCAN;
              rep_q          <= REP_NONE;
              lock_q         <= 1'b0;
              prefix_count_q <= '0;
            end
          end
          SCAN: begin
            if (pop) begin
              if (cls.is_seg) begin
                seg_update_q       <= 1'b1;
                segment_override_q <= 1'b1;
                override_in_q      <= seg_code(bus.fifo_rd_data);
                prefix_count_q     <= count_inc;
              end else if (cls.is_lock) begin
                lock_q         <= 1'b1;
                prefix_count_q <= count_inc;
              end else if (cls.is_rep) begin
                rep_q          <= cls.rep_z ? REP_E : REP_NE;
                prefix_count_q <= count_inc;
              end else begin
                opcode_q       <= bus.fifo_rd_data;
                opcode_valid_q <= 1'b1;
                state          <= HOLD;
              end
            end
          end
          HOLD: begin
            if (bus.opcode_ack) begin
              opcode_valid_q <= 1'b0;
              state          <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.fifo_rd_en       = pop;
  assign bus.seg_update       = seg_update_q;
  assign bus.segment_override = segment_override_q;
  assign bus.override_in      = override_in_q;
  assign bus.rep              = rep_q;
  assign bus.lock             = lock_q;
  assign bus.prefix_count     = prefix_count_q;
  assign bus.opcode           = opcode_q;
  assign bus.opcode_valid     = opcode_valid_q;

endmodule

// File: tb/tb_prefix_sequencer.sv
// Self-checking bench for prefix_sequencer: show-ahead FIFO model, scoreboards
// for segment-override pulses and opcodes, table of instructions plus corner cases.
module tb_prefix_sequencer;

  localparam int unsigned COUNT_W = 4;

  typedef struct {
    logic [5:0][7:0] b;
    int              n;
    logic [1:0]      rep;
    logic            lock;
    logic [3:0]      cnt;
    logic [7:0]      op;
    logic            adj;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n;

  logic [7:0] fifo_q[$];
  logic [1:0] exp_seg[$];
  logic [7:0] exp_op[$];
  int         seg_cyc[$];
  int         cyc;
  int         checks;
  int         errors;
  logic       last_rd;

  always #5 clk = ~clk;

  prefix_sequencer_if #(.COUNT_W(COUNT_W)) bus ();

  prefix_sequencer #(.COUNT_W(COUNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected segment code of a byte, or -1 when it is not a segment prefix.
  function automatic int tb_seg(input logic [7:0] b);
    case (b)
      8'h26:   return 0;
      8'h2E:   return 1;
      8'h36:   return 2;
      8'h3E:   return 3;
      default: return -1;
    endcase
  endfunction

  task automatic refresh();
    bus.fifo_empty   = (fifo_q.size() == 0);
    bus.fifo_rd_data = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
  endtask

  task automatic push_byte(input logic [7:0] b);
    int s;
    fifo_q.push_back(b);
    s = tb_seg(b);
    if (s >= 0) exp_seg.push_back(2'(s));
    refresh();
  endtask

  // One clock: sample the pop request mid-cycle, apply it after the edge, monitor pulses.
  task automatic step();
    logic [1:0] e;
    @(negedge clk);
    last_rd = bus.fifo_rd_en;
    @(posedge clk);
    #1;
    cyc++;
    if (last_rd) begin
      if (fifo_q.size() == 0) chk("pop_on_empty", 32'(1), 32'(0));
      else void'(fifo_q.pop_front());
    end
    refresh();
    if (bus.seg_update) begin
      chk("seg_qualifier", 32'(bus.segment_override), 32'(1));
      if (exp_seg.size() == 0) begin
        chk("seg_unexpected", 32'(1), 32'(0));
      end else begin
        e = exp_seg.pop_front();
        chk("seg_code", 32'(bus.override_in), 32'(e));
      end
      seg_cyc.push_back(cyc);
    end
  endtask

  task automatic wait_valid(input string name, input int budget);
    int k;
    k = 0;
    while (!bus.opcode_valid && k < budget) begin
      step();
      k++;
    end
    if (!bus.opcode_valid) chk({name, "_timeout"}, 32'(0), 32'(1));
  endtask

  // Decoder accepts the presented opcode; scoreboard compares it.
  task automatic handshake(input string name);
    logic [7:0] e;
    if (exp_op.size() == 0) begin
      chk({name, "_no_exp_op"}, 32'(1), 32'(0));
    end else begin
      e = exp_op.pop_front();
      chk({name, "_opcode"}, 32'(bus.opcode), 32'(e));
    end
    bus.opcode_ack = 1'b1;
    step();
    bus.opcode_ack = 1'b0;
    chk({name, "_valid_drop"}, 32'(bus.opcode_valid), 32'(0));
    chk({name, "_seg_drained"}, 32'(exp_seg.size()), 32'(0));
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_rd_en"}, 32'(bus.fifo_rd_en), 32'(0));
    chk({name, "_seg_update"}, 32'(bus.seg_update), 32'(0));
    chk({name, "_seg_ovr"}, 32'(bus.segment_override), 32'(0));
    chk({name, "_override_in"}, 32'(bus.override_in), 32'(0));
    chk({name, "_rep"}, 32'(bus.rep), 32'(0));
    chk({name, "_lock"}, 32'(bus.lock), 32'(0));
    chk({name, "_count"}, 32'(bus.prefix_count), 32'(0));
    chk({name, "_opcode"}, 32'(bus.opcode), 32'(0));
    chk({name, "_valid"}, 32'(bus.opcode_valid), 32'(0));
  endtask

  task automatic run_vec(input string name, input vec_t v);
    for (int i = 0; i < v.n; i++) push_byte(v.b[i]);
    exp_op.push_back(v.op);
    seg_cyc.delete();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    wait_valid(name, 40);
    chk({name, "_rep"}, 32'(bus.rep), 32'(v.rep));
    chk({name, "_lock"}, 32'(bus.lock), 32'(v.lock));
    chk({name, "_count"}, 32'(bus.prefix_count), 32'(v.cnt));
    if (v.adj) begin
      if (seg_cyc.size() < 2) chk({name, "_seg_pulses"}, 32'(seg_cyc.size()), 32'(2));
      else chk({name, "_seg_adjacent"}, 32'(seg_cyc[1] - seg_cyc[0]), 32'(1));
    end
    handshake(name);
  endtask

  vec_t vecs[5];

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    reset_n = 1'b0;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.opcode_ack = 1'b0;
    refresh();

    vecs[0] = '{b: {8'h00, 8'h00, 8'h00, 8'h00, 8'h8B, 8'h2E}, n: 2, rep: 2'b00, lock: 1'b0, cnt: 4'd1, op: 8'h8B, adj: 1'b0};
    vecs[1] = '{b: {8'h00, 8'h00, 8'hA4, 8'hF3, 8'h3E, 8'h26}, n: 4, rep: 2'b11, lock: 1'b0, cnt: 4'd3, op: 8'hA4, adj: 1'b1};
    vecs[2] = '{b: {8'h00, 8'h00, 8'hAA, 8'h36, 8'hF2, 8'hF0}, n: 4, rep: 2'b10, lock: 1'b1, cnt: 4'd3, op: 8'hAA, adj: 1'b0};
    vecs[3] = '{b: {8'h00, 8'h00, 8'h6C, 8'hF2, 8'hF3, 8'hF2}, n: 4, rep: 2'b10, lock: 1'b0, cnt: 4'd3, op: 8'h6C, adj: 1'b0};
    vecs[4] = '{b: {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h90}, n: 1, rep: 2'b00, lock: 1'b0, cnt: 4'd0, op: 8'h90, adj: 1'b0};

    #22;
    chk_zero("reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    for (int i = 0; i < 5; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Empty FIFO after start: no pops, then opcode one cycle after the push.
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("empty_no_pop", 32'(last_rd), 32'(0));
    end
    chk("empty_no_valid", 32'(bus.opcode_valid), 32'(0));
    push_byte(8'h90);
    exp_op.push_back(8'h90);
    step();
    chk("empty_valid_latency", 32'(bus.opcode_valid), 32'(1));
    for (int i = 0; i < 4; i++) begin
      step();
      chk("hold_valid", 32'(bus.opcode_valid), 32'(1));
      chk("hold_opcode", 32'(bus.opcode), 32'(8'h90));
    end
    handshake("empty");

    // 17 LOCK prefixes: counter saturates.
    for (int i = 0; i < 17; i++) push_byte(8'hF0);
    push_byte(8'h90);
    exp_op.push_back(8'h90);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    wait_valid("sat", 60);
    chk("sat_count", 32'(bus.prefix_count), 32'(15));
    chk("sat_lock", 32'(bus.lock), 32'(1));
    chk("sat_rep", 32'(bus.rep), 32'(0));
    handshake("sat");

    // Flush with a segment prefix at the head.
    push_byte(8'hF3);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    chk("flush_pre_rep", 32'(bus.rep), 32'(2'b11));
    fifo_q.push_back(8'h36);
    refresh();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("flush_no_pop", 32'(last_rd), 32'(0));
    chk("flush_rep", 32'(bus.rep), 32'(0));
    chk("flush_lock", 32'(bus.lock), 32'(0));
    chk("flush_count", 32'(bus.prefix_count), 32'(0));
    chk("flush_valid", 32'(bus.opcode_valid), 32'(0));
    step();
    chk("flush_idle_no_pop", 32'(last_rd), 32'(0));
    chk("flush_head_kept", 32'(fifo_q.size()), 32'(1));
    exp_seg.push_back(2'd2);
    run_vec("after_flush", '{b: {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h8B}, n: 1,
                             rep: 2'b00, lock: 1'b0, cnt: 4'd1, op: 8'h8B, adj: 1'b0});

    // Reset mid-scan after REPNE.
    push_byte(8'hF2);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    chk("rst_pre_rep", 32'(bus.rep), 32'(2'b10));
    chk("rst_pre_count", 32'(bus.prefix_count), 32'(1));
    reset_n = 1'b0;
    #1;
    chk_zero("midscan_reset");
    step();
    step();
    chk("rst_held_no_pop", 32'(last_rd), 32'(0));
    reset_n = 1'b1;
    run_vec("after_reset", '{b: {8'h00, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hF3}, n: 2,
                             rep: 2'b11, lock: 1'b0, cnt: 4'd1, op: 8'hAA, adj: 1'b0});

    chk("fifo_drained", 32'(fifo_q.size()), 32'(0));
    chk("op_scoreboard_empty", 32'(exp_op.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prefix_sequencer.md
Name: prefix_sequencer

Overview:
Front-end controller that drives the segment override unit's update, segment_override and override_in inputs.
- Pulls instruction bytes from the prefetch FIFO and consumes 8086 prefix bytes: segment overrides 26/2E/36/3E, LOCK F0, REPNE F2, REP F3.
- Tracks the REP and LOCK qualifiers and counts consumed prefixes for IP rewind on interrupted string ops.
- Hands the first non-prefix byte to the decoder with a valid/ack handshake.
- Sits between the prefetch FIFO, the decoder and the segment override unit.

Parameters:
COUNT_W, 4, width of prefix counter; saturates at 2**COUNT_W-1.

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
start  input  1  begin prefix/opcode scan for a new instruction (same strobe as next_instruction)
flush  input  1  abandon current scan (branch, interrupt)
fifo_empty  input  1  prefetch FIFO empty
fifo_rd_data  input  8  show-ahead head byte, valid when !fifo_empty
fifo_rd_en  output  1  pop head byte this cycle
seg_update  output  1  one-cycle pulse to the override unit's update input
segment_override  output  1  qualifies seg_update; high together with it
override_in  output  2  segment code: ES=0, CS=1, SS=2, DS=3 (= byte[4:3])
rep  output  2  00 none, 10 REPNE, 11 REP
lock  output  1  LOCK prefix seen
prefix_count  output  COUNT_W  prefixes consumed this instruction
opcode  output  8  first non-prefix byte
opcode_valid  output  1  opcode presented to decoder
opcode_ack  input  1  decoder accepts opcode

Behaviour:
- Reset: state=IDLE. All outputs 0: fifo_rd_en, seg_update, segment_override, override_in, rep, lock, prefix_count, opcode, opcode_valid.

States:
- IDLE:
  - fifo_rd_en=0.
  - start -> SCAN; the same edge clears rep, lock and prefix_count.
  - start in SCAN or HOLD is ignored.
- SCAN:
  - fifo_rd_en = !fifo_empty && !flush (combinational); a pop occurs on every cycle with fifo_rd_en=1.
  - Popped byte is a segment prefix: next cycle seg_update=1, segment_override=1, override_in=byte[4:3] (registered, exactly one cycle); prefix_count++.
  - Popped byte is F0: lock<=1, count++.
  - Popped byte is F2/F3: rep<={1,byte[0]}, count++.
  - Popped byte is anything else: opcode<=byte, opcode_valid<=1, -> HOLD.
  - One byte per cycle; back-to-back prefixes pulse seg_update on consecutive cycles.
  - Last segment prefix wins (the unit latches each pulse). Last REP/REPNE wins.
  - FIFO empty: wait in SCAN with no pop and no state change.
- HOLD:
  - opcode and opcode_valid stable until opcode_ack; ack -> IDLE with opcode_valid<=0.
  - rep, lock and prefix_count hold until the next start.

Counter and flush rules:
- prefix_count saturates at 2**COUNT_W-1; prefix processing continues (8086 has no prefix limit).
- flush from any state -> IDLE next edge: opcode_valid<=0, rep<=0, lock<=0, prefix_count<=0, seg_update<=0.
  - flush suppresses a same-cycle pop and wins over a same-cycle start or opcode_ack.
  - A seg_update already asserted in the flush cycle is not retracted; the override unit's own flush clears it.
- reset_n mid-scan: immediate return to reset values; no pop is lost or duplicated at the FIFO, since fifo_rd_en drops asynchronously.
- Latency: prefix byte pop -> seg_update 1 cycle; opcode byte pop -> opcode_valid 1 cycle; minimum instruction start -> opcode_valid is 2 cycles (start edge, then pop).

Decomposition:
- Shared package:
  - segment code constants ES/CS/SS/DS (already shared with the override unit);
  - prefix byte constants PFX_ES, PFX_CS, PFX_SS, PFX_DS, PFX_LOCK, PFX_REPNE, PFX_REP;
  - enum prefix_state_t {IDLE, SCAN, HOLD};
  - rep encoding constants REP_NONE, REP_NE, REP_E.
- One sub-module is natural: prefix_classify, a combinational byte -> {is_seg, is_lock, is_rep, rep_z}.
- FSM, counter and registers stay in prefix_sequencer.

Test Plan:
1. start; FIFO holds 2E, 8B -> pop 2E; next cycle seg_update=1, override_in=1; pop 8B; opcode=8B, opcode_valid=1, prefix_count=1, rep=00; ack -> IDLE.
2. FIFO 26, 3E, F3, A4 -> seg_update pulses on two consecutive cycles with override_in 0 then 3; rep=11, lock=0, prefix_count=3, opcode=A4.
3. FIFO empty for 5 cycles after start, then 90 -> fifo_rd_en stays 0, no seg_update; opcode=90 valid one cycle after the push; opcode_ack held low 4 cycles -> opcode_valid stays 1 with opcode stable.
4. 17 consecutive F0 bytes then 90, COUNT_W=4 -> prefix_count saturates at 15, lock=1, opcode=90.
5. flush asserted in the same cycle a 36 byte is at the FIFO head -> fifo_rd_en=0, no seg_update, state IDLE, rep/lock/count=0; the following start pops 36 normally.
6. reset_n low during SCAN after F2 -> all outputs 0 asynchronously; after release and start with FIFO F3, AA -> rep=11 (REPNE not retained), count=1.
